// File: rtl/dm_wait_unit.sv
// Data memory with a req/ready handshake and WAIT_CYCLES wait states.
// Supports byte, half and word access, and reports misaligned or out-of-range requests.
module dm_wait_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misaligned,
  output logic        oob
);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = lo[0];
      2'b10:   m = (lo != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic f_oob(input logic [31:0] a);
    return (a >> (ADDR_WIDTH + 2)) != 32'd0;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] w;
    w = old;
    case (sz)
      2'b00:   w[{lo, 3'b000} +: 8] = wd[7:0];
      2'b01:   w[{lo[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   w = wd;
      default: w = old;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] sz,
                                         input logic [1:0] lo, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [1:0]            state_r;
  logic [3:0]            cnt_r;
  logic                  we_r;
  logic [1:0]            size_r;
  logic                  sign_ext_r;
  logic [31:0]           addr_r;
  logic [31:0]           wdata_r;
  logic [31:0]           pc_r;
  logic [31:0]           rdata_r;
  logic                  ready_r;
  logic                  mis_r;
  logic                  oob_r;
  logic [31:0]           mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic                  commit_s;
  logic                  mis_in_s;
  logic                  oob_in_s;
  logic [31:0]           merged_s;
  logic [31:0]           load_s;

  assign word_idx_s = addr_r[ADDR_WIDTH+1:2];
  assign commit_s   = (state_r == ST_BUSY) && (cnt_r == 4'd0);
  assign mis_in_s   = f_misaligned(size, addr[1:0]);
  assign oob_in_s   = f_oob(addr);
  assign merged_s   = f_merge(mem_r[word_idx_s], wdata_r, size_r, addr_r[1:0]);
  assign load_s     = f_load(mem_r[word_idx_s], size_r, addr_r[1:0], sign_ext_r);

  assign rdata      = rdata_r;
  assign ready      = ready_r;
  assign busy       = (state_r != ST_IDLE);
  assign misaligned = mis_r;
  assign oob        = oob_r;

  // Handshake FSM: latch the request, count wait states, then present one ready pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      size_r     <= 2'b00;
      sign_ext_r <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      pc_r       <= 32'd0;
      rdata_r    <= 32'd0;
      ready_r    <= 1'b0;
      mis_r      <= 1'b0;
      oob_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          mis_r   <= 1'b0;
          oob_r   <= 1'b0;
          if (req) begin
            we_r       <= we;
            size_r     <= size;
            sign_ext_r <= sign_ext;
            addr_r     <= addr;
            wdata_r    <= wdata;
            pc_r       <= pc;
            // Errors skip the wait states and complete with a zeroed result.
            if (mis_in_s || oob_in_s) begin
              state_r <= ST_DONE;
              ready_r <= 1'b1;
              mis_r   <= mis_in_s;
              oob_r   <= oob_in_s;
              rdata_r <= 32'd0;
            end else begin
              state_r <= ST_BUSY;
              cnt_r   <= WAIT_INIT;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= ST_DONE;
            ready_r <= 1'b1;
            if (!we_r) begin
              rdata_r <= load_s;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          mis_r   <= 1'b0;
          oob_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          mis_r   <= 1'b0;
          oob_r   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: cleared on reset, written only on the commit edge of a legal store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (commit_s && we_r) begin
      mem_r[word_idx_s] <= merged_s;
      $display("%d@%h: *%h <= %h", $time, pc_r, {addr_r[31:2], 2'b00}, merged_s);
    end
  end

endmodule

// File: tb/tb_dm_wait_unit.sv
// Randomized and directed bench for dm_wait_unit against a transaction-level memory model.
// A second instance with zero wait states checks the back-to-back handshake timing.
module tb_dm_wait_unit;
  localparam int AW    = 10;
  localparam int W     = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc, rdata;
  logic        ready, busy, misaligned, oob;

  logic        reset0, req0, we0, sign_ext0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0, pc0, rdata0;
  logic        ready0, busy0, misaligned0, oob0;

  dm_wait_unit #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .pc(pc), .rdata(rdata), .ready(ready), .busy(busy),
    .misaligned(misaligned), .oob(oob));

  dm_wait_unit #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .size(size0), .sign_ext(sign_ext0),
    .addr(addr0), .wdata(wdata0), .pc(pc0), .rdata(rdata0), .ready(ready0), .busy(busy0),
    .misaligned(misaligned0), .oob(oob0));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit checking = 0;

  // Model state: sparse word memory plus the one transaction in flight.
  logic [31:0] mmem [int];
  bit          txn_valid = 0;
  int          acc_cyc = -10, rdy_cyc = -10, abort_at = -1;
  logic [31:0] txn_rdata, txn_word;
  bit          txn_mis, txn_oob, txn_wr;
  int          txn_idx;
  logic [31:0] cur_rdata = 32'd0;
  int          dut_ready_cyc = -1;
  logic        seen_mis = 1'b0, seen_oob = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mget(input int idx);
    return mmem.exists(idx) ? mmem[idx] : 32'd0;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return (a % 32'd2) != 32'd0;
      2'd2:    return (a % 32'd4) != 32'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_oob(input logic [31:0] a);
    return longint'(a) >= (longint'(1) << (AW + 2));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] sz,
                                         input logic [31:0] a, input bit sx);
    int sh;
    logic [31:0] v;
    case (sz)
      2'd0: begin
        sh = 8 * int'(a % 32'd4);
        v = (word >> sh) & 32'h0000_00FF;
        if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        sh = 16 * int'((a % 32'd4) / 32'd2);
        v = (word >> sh) & 32'h0000_FFFF;
        if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [31:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    case (sz)
      2'd0: begin sh = 8 * int'(a % 32'd4); mask = 32'hFF << sh; end
      2'd1: begin sh = 16 * int'((a % 32'd4) / 32'd2); mask = 32'hFFFF << sh; end
      default: begin sh = 0; mask = 32'hFFFF_FFFF; end
    endcase
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic exp_busy, exp_ready;
    @(negedge clk);
    if (cyc == abort_at) begin
      txn_valid = 0;
      cur_rdata = 32'd0;
      mmem.delete();
    end
    if (txn_valid && cyc == rdy_cyc) begin
      cur_rdata = txn_rdata;
      if (txn_wr) mmem[txn_idx] = txn_word;
    end
    if (checking) begin
      exp_busy  = txn_valid && cyc >= acc_cyc && cyc <= rdy_cyc;
      exp_ready = txn_valid && cyc == rdy_cyc;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("rdata", rdata, cur_rdata);
      chk("misaligned", 32'(misaligned), 32'(exp_ready && txn_mis));
      chk("oob", 32'(oob), 32'(exp_ready && txn_oob));
      if (ready) begin
        dut_ready_cyc = cyc;
        seen_mis = misaligned;
        seen_oob = oob;
      end
    end
  end

  task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; pc = $urandom;
    @(posedge clk); #1;
    acc_cyc = cyc;
    txn_mis = m_mis(sz, a);
    txn_oob = m_oob(a);
    txn_idx = int'((a >> 2) & 32'(DEPTH - 1));
    txn_wr  = 0;
    if (txn_mis || txn_oob) begin
      rdy_cyc   = acc_cyc;
      txn_rdata = 32'd0;
    end else begin
      rdy_cyc = acc_cyc + W + 1;
      if (w) begin
        txn_rdata = cur_rdata;
        txn_wr    = 1;
        txn_word  = m_merge(mget(txn_idx), sz, a, wd);
      end else begin
        txn_rdata = m_load(mget(txn_idx), sz, a, sx);
      end
    end
    txn_valid = 1;
    req = 1'b0;
  endtask

  // Inputs are scrambled while the access is in flight; the DUT must ignore them.
  task automatic wait_done();
    while (cyc < rdy_cyc + 1) begin
      req = 1'($urandom_range(0, 1)); we = 1'($urandom); size = 2'($urandom);
      addr = $urandom; wdata = $urandom; sign_ext = 1'($urandom);
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic access(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd);
    issue(w, sz, sx, a, wd);
    wait_done();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    abort_at = cyc + 1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int a0, pulses, p;
    logic [31:0] ra;
    logic [1:0]  rs;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0; pc = 32'd0;
    reset0 = 1'b1; req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; sign_ext0 = 1'b0;
    addr0 = 32'd0; wdata0 = 32'd0; pc0 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checking = 1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    chk("sw_latency", 32'(dut_ready_cyc - acc_cyc + 1), 32'd4);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    chk("lw_0x10", rdata, 32'h1234_5678);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
    chk("model_sb", mget(4), 32'h1234_AB78);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'd0);
    chk("lb_0x11", rdata, 32'hFFFF_FFAB);
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'd0);
    chk("lbu_0x11", rdata, 32'h0000_00AB);
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
    chk("model_sh", mget(4), 32'h8001_AB78);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
    chk("lh_0x12", rdata, 32'hFFFF_8001);
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    chk("lhu_0x12", rdata, 32'h0000_8001);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    chk("lw_merged", rdata, 32'h8001_AB78);

    access(1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
    chk("mis_latency", 32'(dut_ready_cyc - acc_cyc + 1), 32'd1);
    chk("lw_0x13_mis", 32'(seen_mis), 32'd1);
    chk("lw_0x13_rdata", rdata, 32'd0);
    access(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000_BEEF);
    chk("sh_0x15_mis", 32'(seen_mis), 32'd1);
    access(1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
    chk("lw_0x14_unchanged", rdata, 32'd0);

    access(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D);
    access(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1111_1111);
    chk("sw_oob_flag", 32'(seen_oob), 32'd1);
    chk("sw_oob_nomis", 32'(seen_mis), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
    chk("lw_0x0_kept", rdata, 32'hCAFE_F00D);

    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    do_reset();
    chk("abort_busy", 32'(busy), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    chk("lw_0x20_aborted", rdata, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    chk("lw_0x10_cleared", rdata, 32'd0);

    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ra = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) ra = ra | (32'd1 << $urandom_range(12, 31));
      rs = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      access(1'($urandom), rs, 1'($urandom), ra, $urandom);
    end

    // Zero-wait instance with req held high: accept every third cycle.
    reset0 = 1'b0;
    @(posedge clk); #1;
    a0 = cyc;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      p = (cyc - a0) % 3;
      chk("w0_busy", 32'(busy0), 32'(p != 2));
      chk("w0_ready", 32'(ready0), 32'(p == 1));
      if (ready0) begin
        pulses++;
        chk("w0_rdata", rdata0, 32'd0);
        chk("w0_flags", 32'({misaligned0, oob0}), 32'd0);
      end
    end
    chk("w0_pulse_count", 32'(pulses), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
